// File: rtl/dec_pkg.sv
// Shared mode encoding and counter sizing for the dec_n_scan family.
// Pure definitions: no latency, no flow control.
package dec_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // Width of a counter that must hold 0..value-1, never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/dec_n_onehot.sv
// Combinational N-to-2^N one-hot decoder with no enable.
// Zero latency, no backpressure.
module dec_n_onehot #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [(1<<N)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/dec_n_scan.sv
// One-hot select driver with DIRECT decode, SCAN walker and PULSE strobe modes.
// All outputs registered, 1 clock from inputs; no backpressure, PULSE reports busy and drops load while busy.
module dec_n_scan
    import dec_pkg::*;
#(
    parameter int N         = 3,
    parameter int DWELL     = 4,
    parameter int PULSE_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      a,
    input  logic              load,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              busy,
    output logic              wrap
);

    localparam int DW = cnt_width(DWELL);
    localparam int PW = cnt_width(PULSE_LEN);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN - 1);
    localparam logic [N-1:0]  IDX_LAST   = '1;

    logic [DW-1:0]     dwell_cnt;
    logic [PW-1:0]     pulse_cnt;
    logic [1:0]        prev_mode;
    logic              mode_chg;
    logic [DW-1:0]     dwell_eff;
    logic [PW-1:0]     pulse_eff;
    logic              busy_eff;
    logic              scan_step;
    logic [N-1:0]      dec_sel;
    logic [(1<<N)-1:0] dec_out;

    // A mode switch acts as if counters and busy were already clear on this edge.
    always_comb begin
        mode_chg  = (mode != prev_mode);
        dwell_eff = mode_chg ? '0 : dwell_cnt;
        pulse_eff = mode_chg ? '0 : pulse_cnt;
        busy_eff  = busy & ~mode_chg;
        scan_step = (dwell_eff == DWELL_LAST);
        dec_sel   = a;
        if (mode == MODE_SCAN) begin
            dec_sel = scan_step ? idx + 1'b1 : idx;
        end
    end

    dec_n_onehot #(.N(N)) u_onehot (
        .sel    (dec_sel),
        .onehot (dec_out)
    );

    always_ff @(posedge clk) begin
        prev_mode <= mode;
        if (!rst_n) begin
            y         <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
            pulse_cnt <= '0;
        end else begin
            wrap      <= 1'b0;
            dwell_cnt <= dwell_eff;
            pulse_cnt <= pulse_eff;
            busy      <= busy_eff;
            if (!en) begin
                y         <= '0;
                busy      <= 1'b0;
                dwell_cnt <= '0;
                pulse_cnt <= '0;
            end else begin
                case (mode)
                    MODE_DIRECT: begin
                        y   <= dec_out;
                        idx <= a;
                    end
                    MODE_SCAN: begin
                        y <= dec_out;
                        if (scan_step) begin
                            dwell_cnt <= '0;
                            idx       <= dec_sel;
                            wrap      <= (idx == IDX_LAST);
                        end else begin
                            dwell_cnt <= dwell_eff + 1'b1;
                        end
                    end
                    MODE_PULSE: begin
                        // While busy y holds; load is ignored until busy has fallen.
                        if (busy_eff) begin
                            if (pulse_eff == '0) begin
                                y    <= '0;
                                busy <= 1'b0;
                            end else begin
                                pulse_cnt <= pulse_eff - 1'b1;
                            end
                        end else if (load) begin
                            y         <= dec_out;
                            idx       <= a;
                            busy      <= 1'b1;
                            pulse_cnt <= PULSE_INIT;
                        end else begin
                            y <= '0;
                        end
                    end
                    default: begin
                        y    <= '0;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dec_n_scan.sv
// Directed bench for dec_n_scan: two instances (DWELL=4 and DWELL=1) against a behavioural model,
// plus hand-computed spot checks.
module tb_dec_n_scan;

    localparam int PL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [2:0] a;
    logic       load;

    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       busy0, busy1, wrap0, wrap1;

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    dec_n_scan #(.N(3), .DWELL(4), .PULSE_LEN(PL)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .load(load),
        .y(y0), .idx(idx0), .busy(busy0), .wrap(wrap0)
    );

    dec_n_scan #(.N(3), .DWELL(1), .PULSE_LEN(PL)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .load(load),
        .y(y1), .idx(idx1), .busy(busy1), .wrap(wrap1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index as an integer, pulse tracked as cycles already shown.
    int         dw[2] = '{4, 1};
    int         m_idx[2], m_ticks[2], m_shown[2];
    logic [7:0] m_y[2];
    bit         m_busy[2], m_wrap[2];
    logic [1:0] m_pm[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_idx[k] = 0; m_ticks[k] = 0; m_shown[k] = 0;
                m_y[k] = 8'h00; m_busy[k] = 1'b0; m_wrap[k] = 1'b0;
            end else begin
                m_wrap[k] = 1'b0;
                if (mode != m_pm[k]) begin
                    m_ticks[k] = 0; m_shown[k] = 0; m_busy[k] = 1'b0;
                end
                if (!en) begin
                    m_y[k] = 8'h00; m_busy[k] = 1'b0; m_ticks[k] = 0; m_shown[k] = 0;
                end else begin
                    case (mode)
                        2'b00: begin
                            m_idx[k] = int'(a);
                            m_y[k]   = 8'(1 << a);
                        end
                        2'b01: begin
                            m_ticks[k]++;
                            if (m_ticks[k] == dw[k]) begin
                                m_ticks[k] = 0;
                                m_wrap[k]  = (m_idx[k] == 7);
                                m_idx[k]   = (m_idx[k] + 1) % 8;
                            end
                            m_y[k] = 8'(1 << m_idx[k]);
                        end
                        2'b10: begin
                            if (m_busy[k]) begin
                                if (m_shown[k] == PL) begin
                                    m_y[k] = 8'h00; m_busy[k] = 1'b0;
                                end else begin
                                    m_shown[k]++;
                                end
                            end else if (load) begin
                                m_idx[k] = int'(a); m_y[k] = 8'(1 << a);
                                m_busy[k] = 1'b1; m_shown[k] = 1;
                            end else begin
                                m_y[k] = 8'h00;
                            end
                        end
                        default: begin
                            m_y[k] = 8'h00; m_busy[k] = 1'b0;
                        end
                    endcase
                end
            end
            m_pm[k] = mode;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_y0", y0, m_y[0]);
            chk("model_idx0", idx0, m_idx[0]);
            chk("model_busy0", busy0, m_busy[0]);
            chk("model_wrap0", wrap0, m_wrap[0]);
            chk("model_y1", y1, m_y[1]);
            chk("model_idx1", idx1, m_idx[1]);
            chk("model_busy1", busy1, m_busy[1]);
            chk("model_wrap1", wrap1, m_wrap[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_dir[8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] exp_hold[8] = '{8'h40, 8'h40, 8'h40, 8'h00, 8'h40, 8'h40, 8'h40, 8'h00};

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; a = 3'd5; load = 1'b0;
        step(); step();
        chk("rst_y", y0, 8'h00);
        chk("rst_idx", idx0, 3'd0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_wrap", wrap0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("first_y", y0, 8'h20);
        chk("first_idx", idx0, 3'd5);

        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            step();
            chk("direct_y", y0, exp_dir[i]);
        end
        en = 1'b0;
        step();
        chk("en_off_y", y0, 8'h00);
        chk("en_off_idx", idx0, 3'd7);

        en = 1'b1; mode = 2'b01; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e <= 3) chk("scan_e1_3", y0, 8'h01);
            if (e == 4) chk("scan_e4", y0, 8'h02);
            if (e == 8) chk("scan_d1_wrap", wrap1, 1'b1);
            if (e == 31) chk("scan_prewrap", wrap0, 1'b0);
            if (e == 32) begin
                chk("scan_wrap_y", y0, 8'h01);
                chk("scan_wrap_idx", idx0, 3'd0);
                chk("scan_wrap", wrap0, 1'b1);
            end
        end
        step();
        chk("wrap_one_cycle", wrap0, 1'b0);
        repeat (15) step();
        chk("scan_idx4", idx0, 3'd4);
        rst_n = 1'b0;
        step();
        chk("midscan_rst_y", y0, 8'h00);
        chk("midscan_rst_idx", idx0, 3'd0);
        chk("midscan_rst_y1", y1, 8'h00);
        rst_n = 1'b1;
        step();
        chk("scan_restart_y", y0, 8'h01);
        chk("scan_restart_idx", idx0, 3'd0);

        mode = 2'b10; a = 3'd6; load = 1'b1;
        step();
        chk("pulse_k_y", y0, 8'h40);
        chk("pulse_k_busy", busy0, 1'b1);
        load = 1'b0;
        step();
        chk("pulse_k1_y", y0, 8'h40);
        step();
        chk("pulse_k2_y", y0, 8'h40);
        chk("pulse_k2_busy", busy0, 1'b1);
        step();
        chk("pulse_k3_y", y0, 8'h00);
        chk("pulse_k3_busy", busy0, 1'b0);

        load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("pulse_held_y", y0, exp_hold[i]);
        end
        load = 1'b0;
        step();

        load = 1'b1;
        step();
        chk("abort_busy", busy0, 1'b1);
        load = 1'b0; en = 1'b0;
        step();
        chk("abort_y", y0, 8'h00);
        chk("abort_busy0", busy0, 1'b0);
        en = 1'b1;
        step();
        chk("after_abort_y", y0, 8'h00);

        a = 3'd3; load = 1'b1;
        step();
        chk("pulse_a3_y", y0, 8'h08);
        load = 1'b0; rst_n = 1'b0;
        step();
        chk("midpulse_rst_y", y0, 8'h00);
        chk("midpulse_rst_busy", busy0, 1'b0);
        chk("midpulse_rst_idx", idx0, 3'd0);
        rst_n = 1'b1;
        step();

        a = 3'd2; load = 1'b1;
        step();
        load = 1'b0; mode = 2'b11;
        step();
        chk("rsvd_y", y0, 8'h00);
        chk("rsvd_busy", busy0, 1'b0);
        chk("rsvd_idx", idx0, 3'd2);

        mode = 2'b01;
        repeat (6) step();
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (5) step();
        mode = 2'b00; a = 3'd1;
        step();
        mode = 2'b01;
        repeat (10) step();
        mode = 2'b10; load = 1'b1;
        step();
        mode = 2'b01; load = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
